// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed digit scanner with refresh prescaler and frame shadow
// Optional: `define DISPLAY_SCAN_GHOST_BLANK_EN for one-cycle anode dead time after each slot advance.
module display_scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DIV      = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       blank_mask,
    output logic [WIDTH-1:0]          digit_out,
    output logic [CHANNELS-1:0]       an,
    output logic [$clog2(CHANNELS)-1:0] sel,
    output logic                      scan_tick
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                scan_tick_q, scan_tick_d;
    logic [WIDTH-1:0]    digit_out_q, digit_out_d;
    logic [CHANNELS-1:0] an_q, an_d;
    logic [WIDTH-1:0]    dig_sh_q [CHANNELS];
    logic [WIDTH-1:0]    dig_sh_d [CHANNELS];
    logic [CHANNELS-1:0] mask_sh_q, mask_sh_d;
    logic                tick;
    logic                wrap;

    always_comb begin
        tick = en && (cnt_q == CNT_W'(DIV - 1));
        wrap = tick && (sel_q == SEL_W'(CHANNELS - 1));

        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        sel_d = sel_q;
        if (tick) begin
            sel_d = wrap ? '0 : sel_q + SEL_W'(1);
        end

        // Inputs are sampled only at the frame boundary so a frame never shows mixed data.
        mask_sh_d = wrap ? blank_mask : mask_sh_q;
        for (int i = 0; i < CHANNELS; i++) begin
            dig_sh_d[i] = wrap ? d[i*WIDTH +: WIDTH] : dig_sh_q[i];
        end

        scan_tick_d = tick;
        digit_out_d = dig_sh_d[sel_d];

        an_d = '1;
        if (en && !mask_sh_d[sel_d]) begin
            an_d = ~(CHANNELS'(1) << sel_d);
        end
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
        if (tick) begin
            an_d = '1;
        end
`else
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            sel_q       <= '0;
            scan_tick_q <= 1'b0;
            digit_out_q <= '0;
            an_q        <= '1;
            mask_sh_q   <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                dig_sh_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            scan_tick_q <= scan_tick_d;
            digit_out_q <= digit_out_d;
            an_q        <= an_d;
            mask_sh_q   <= mask_sh_d;
            for (int i = 0; i < CHANNELS; i++) begin
                dig_sh_q[i] <= dig_sh_d[i];
            end
        end
    end

    assign digit_out = digit_out_q;
    assign an        = an_q;
    assign sel       = sel_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - directed bench for display_scan_mux with per-cycle reference model
module tb_display_scan_mux;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int DIV      = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] d = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic [1:0]  sel;
    logic        scan_tick;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit started = 0;

    display_scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .en(en), .d(d), .blank_mask(blank_mask),
        .digit_out(digit_out), .an(an), .sel(sel), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    // Model: position in the scan follows from the number of enabled edges since reset.
    int          ecount;
    bit          last_en;
    logic [15:0] sh_d;
    logic [3:0]  sh_m;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ecount  = 0;
            last_en = 0;
            sh_d    = 16'h0;
            sh_m    = 4'hF;
        end else begin
            last_en = en;
            if (en) begin
                ecount++;
                if (ecount % (DIV * CHANNELS) == 0) begin
                    sh_d = d;
                    sh_m = blank_mask;
                end
            end
        end
    end

    function automatic int m_sel();
        return (ecount / DIV) % CHANNELS;
    endfunction

    function automatic bit m_tick();
        return last_en && ecount > 0 && (ecount % DIV == 0);
    endfunction

    function automatic logic [3:0] m_digit();
        return 4'((sh_d >> (4 * m_sel())) & 16'hF);
    endfunction

    function automatic logic [3:0] m_an();
        bit ghost = 0;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
        ghost = m_tick();
`else
`endif
        if (last_en && !sh_m[m_sel()] && !ghost) return ~(4'b0001 << m_sel());
        return 4'b1111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_sel", 32'(sel), 32'(m_sel()));
            check("model_digit", 32'(digit_out), 32'(m_digit()));
            check("model_an", 32'(an), 32'(m_an()));
            check("model_tick", 32'(scan_tick), 32'(m_tick()));
            check("an_onehot0", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    task automatic run_to(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            #2;
            edge_n++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        en = 1'b1;
        d = 16'h4321;
        started = 1;
        repeat (6) begin
            @(posedge clk);
            #2;
        end
        // Test 1: asynchronous reset between edges
        reset = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_digit", 32'(digit_out), 32'h0);
        check("rst_tick", 32'(scan_tick), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        edge_n = 0;
        blank_mask = 4'h0;
        run_to(3);
        check("first_tick_not_early", 32'(scan_tick), 32'h0);
        run_to(4);
        check("first_tick", 32'(scan_tick), 32'h1);
        check("first_frame_dark", 32'(an), 32'hF);
        // Test 2 and 6: second frame shows captured digits
        run_to(16);
        check("f2_s0_digit", 32'(digit_out), 32'h1);
        check("f2_s0_sel", 32'(sel), 32'h0);
        check("f2_s0_tick", 32'(scan_tick), 32'h1);
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
        check("f2_s0_ghost", 32'(an), 32'hF);
        run_to(17);
        check("f2_s0_an_after_ghost", 32'(an), 32'hE);
`else
        check("f2_s0_an", 32'(an), 32'hE);
`endif
        run_to(20);
        check("f2_s1_digit", 32'(digit_out), 32'h2);
        run_to(21);
        check("f2_s1_an", 32'(an), 32'hD);
        // Test 3: mid-frame change is deferred
        d = 16'h8765;
        run_to(24);
        check("f2_s2_digit_old", 32'(digit_out), 32'h3);
        run_to(29);
        check("f2_s3_digit_old", 32'(digit_out), 32'h4);
        check("f2_s3_an", 32'(an), 32'h7);
        run_to(32);
        check("f3_s0_digit_new", 32'(digit_out), 32'h5);
        run_to(44);
        check("f3_s3_digit_new", 32'(digit_out), 32'h8);
        // Test 4: blank one channel
        d = 16'h4321;
        blank_mask = 4'b0100;
        run_to(53);
        check("f4_s1_an", 32'(an), 32'hD);
        run_to(57);
        check("f4_s2_blank_an", 32'(an), 32'hF);
        check("f4_s2_blank_digit", 32'(digit_out), 32'h3);
        run_to(61);
        check("f4_s3_an", 32'(an), 32'h7);
        blank_mask = 4'h0;
        // Test 5: pause mid-slot
        run_to(73);
        check("f5_s2_an", 32'(an), 32'hB);
        en = 1'b0;
        run_to(74);
        check("pause_an", 32'(an), 32'hF);
        run_to(83);
        check("pause_sel", 32'(sel), 32'h2);
        check("pause_tick", 32'(scan_tick), 32'h0);
        en = 1'b1;
        run_to(84);
        check("resume_an", 32'(an), 32'hB);
        run_to(85);
        check("resume_no_tick", 32'(scan_tick), 32'h0);
        check("resume_sel", 32'(sel), 32'h2);
        run_to(86);
        check("resume_tick", 32'(scan_tick), 32'h1);
        check("resume_sel_adv", 32'(sel), 32'h3);
        run_to(100);
        started = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
